// File: rtl/bcrypt_pkg.sv
// bcrypt_pkg -- shared types and constants for the bcrypt scheduler.
//   state_t   : scheduler FSM states (S_DRAIN only when BCRYPT_SCHED_ABORT_EN)
//   ctext_t   : six 32-bit ciphertext words, word 0 in the MSBs
//   MAGIC     : "OrpheanBeholderScryDoubt" as six big-endian words
//   MIN_COST_DEF, ENC_BLOCKS, CT_WORDS
package bcrypt_pkg;

   localparam int MIN_COST_DEF = 4;
   localparam int ENC_BLOCKS   = 3;
   localparam int CT_WORDS     = 2 * ENC_BLOCKS;

   typedef logic [0:CT_WORDS-1][31:0] ctext_t;

   localparam ctext_t MAGIC = {32'h4F727068, 32'h65616E42, 32'h65686F6C,
                               32'h64657253, 32'h63727944, 32'h6F756274};

   typedef enum logic [3:0] {
      S_IDLE,
      S_SETUP_REQ,
      S_SETUP_WAIT,
      S_LK_REQ,
      S_LK_WAIT,
      S_LS_REQ,
      S_LS_WAIT,
      S_ENC_REQ,
      S_ENC_WAIT,
      S_DONE
`ifdef BCRYPT_SCHED_ABORT_EN
      , S_DRAIN
`endif
   } state_t;

endpackage

// File: rtl/bcrypt_sched_if.sv
// bcrypt_sched_if -- request/response bus between the bcrypt scheduler and
// the expandKey / feistel datapath.
//   ek_start, ek_load_salt, ek_salt, ek_key_sel : expandKey pass request
//   ek_done                                     : expandKey pass complete
//   enc_start, enc_L, enc_R                     : one feistel encipher request
//   enc_resultL, enc_resultR, enc_done          : encipher result
// master = scheduler side, slave = datapath side.
interface bcrypt_sched_if;
   logic         ek_start;
   logic         ek_load_salt;
   logic [127:0] ek_salt;
   logic         ek_key_sel;
   logic         ek_done;
   logic         enc_start;
   logic [31:0]  enc_L;
   logic [31:0]  enc_R;
   logic [31:0]  enc_resultL;
   logic [31:0]  enc_resultR;
   logic         enc_done;

   modport master (
      output ek_start, ek_load_salt, ek_salt, ek_key_sel,
      output enc_start, enc_L, enc_R,
      input  ek_done, enc_resultL, enc_resultR, enc_done
   );

   modport slave (
      input  ek_start, ek_load_salt, ek_salt, ek_key_sel,
      input  enc_start, enc_L, enc_R,
      output ek_done, enc_resultL, enc_resultR, enc_done
   );
endinterface

// File: rtl/bcrypt_sched.sv
// bcrypt_sched -- sequencer for the EksBlowfish cost loop and the final
// 64-round ECB encryption of the magic text.
//   i_clk, i_reset       : clock, synchronous active-high reset
//   i_start/i_cost/i_salt: host command (sampled in IDLE only)
//   i_abort              : only when BCRYPT_SCHED_ABORT_EN is defined
//   o_busy, o_done, o_error, o_hash, o_hash_valid : host status/result
//   dp_if                : expandKey / feistel request bus (master)
// Optional feature macro: BCRYPT_SCHED_ABORT_EN (abort input + DRAIN state).
module bcrypt_sched
   import bcrypt_pkg::*;
#(
   parameter int MIN_COST   = MIN_COST_DEF,
   parameter int MAX_COST   = 31,
   parameter int ENC_ROUNDS = 64
) (
   input  logic           i_clk,
   input  logic           i_reset,
   input  logic           i_start,
   input  logic [4:0]     i_cost,
   input  logic [127:0]   i_salt,
`ifdef BCRYPT_SCHED_ABORT_EN
   input  logic           i_abort,
`endif
   output logic           o_busy,
   output logic           o_done,
   output logic           o_error,
   output logic [191:0]   o_hash,
   output logic           o_hash_valid,
   bcrypt_sched_if.master dp_if
);

   localparam int ITER_W = MAX_COST + 1;
   localparam int RND_W  = $clog2(ENC_ROUNDS);

   state_t              r_state, w_next;
   logic [127:0]        r_salt;
   logic [ITER_W-1:0]   r_iter;
   logic [1:0]          r_blk;
   logic [RND_W-1:0]    r_rnd;
   ctext_t              r_ctext, r_hash;
   logic                r_done, r_error, r_hash_valid;

   logic w_cost_bad, w_accept, w_last_blk;
   logic w_ek_req, w_ek_sel, w_salt_sel, w_enc_req, w_enc_act;

   assign w_cost_bad = (int'(i_cost) < MIN_COST) || (int'(i_cost) > MAX_COST);
   assign w_accept   = (r_state == S_IDLE) && i_start && !w_cost_bad;
   assign w_last_blk = (r_rnd == RND_W'(ENC_ROUNDS - 1)) &&
                       (r_blk == 2'(ENC_BLOCKS - 1));

   // Next state and Moore-style request outputs.
   always_comb begin
      w_next     = r_state;
      w_ek_req   = 1'b0;
      w_ek_sel   = 1'b0;
      w_salt_sel = 1'b0;
      w_enc_req  = 1'b0;
      w_enc_act  = 1'b0;
      unique case (r_state)
         S_IDLE:       if (w_accept) w_next = S_SETUP_REQ;
         S_SETUP_REQ:  begin w_ek_req = 1'b1; w_salt_sel = 1'b1; w_next = S_SETUP_WAIT; end
         S_SETUP_WAIT: begin w_salt_sel = 1'b1; if (dp_if.ek_done) w_next = S_LK_REQ; end
         S_LK_REQ:     begin w_ek_req = 1'b1; w_next = S_LK_WAIT; end
         S_LK_WAIT:    if (dp_if.ek_done) w_next = S_LS_REQ;
         S_LS_REQ:     begin w_ek_req = 1'b1; w_ek_sel = 1'b1; w_next = S_LS_WAIT; end
         S_LS_WAIT: begin
            w_ek_sel = 1'b1;
            if (dp_if.ek_done)
               w_next = (r_iter == ITER_W'(1)) ? S_ENC_REQ : S_LK_REQ;
         end
         S_ENC_REQ:    begin w_enc_req = 1'b1; w_enc_act = 1'b1; w_next = S_ENC_WAIT; end
         S_ENC_WAIT: begin
            w_enc_act = 1'b1;
            if (dp_if.enc_done) w_next = w_last_blk ? S_DONE : S_ENC_REQ;
         end
         S_DONE:       w_next = S_IDLE;
`ifdef BCRYPT_SCHED_ABORT_EN
         S_DRAIN:      if (dp_if.ek_done || dp_if.enc_done) w_next = S_IDLE;
`endif
         default:      w_next = S_IDLE;
      endcase
`ifdef BCRYPT_SCHED_ABORT_EN
      // Abort suppresses a pending request outright; an issued one must
      // finish (DRAIN) unless its done is already here this cycle.
      if (i_abort) begin
         case (r_state)
            S_SETUP_REQ, S_LK_REQ, S_LS_REQ, S_ENC_REQ: begin
               w_next    = S_IDLE;
               w_ek_req  = 1'b0;
               w_enc_req = 1'b0;
            end
            S_SETUP_WAIT, S_LK_WAIT, S_LS_WAIT:
               w_next = dp_if.ek_done ? S_IDLE : S_DRAIN;
            S_ENC_WAIT:
               w_next = dp_if.enc_done ? S_IDLE : S_DRAIN;
            default: ;
         endcase
      end
`endif
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_salt       <= '0;
         r_iter       <= '0;
         r_blk        <= '0;
         r_rnd        <= '0;
         r_ctext      <= MAGIC;
         r_hash       <= '0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
         r_hash_valid <= 1'b0;
      end else begin
         r_state <= w_next;
         r_done  <= (r_state == S_DONE);
         r_error <= (r_state == S_IDLE) && i_start && w_cost_bad;

         if (w_accept) begin
            r_salt       <= i_salt;
            r_iter       <= ITER_W'(1) << i_cost;
            r_hash_valid <= 1'b0;
            r_ctext      <= MAGIC;
         end

         if (r_state == S_LS_WAIT && dp_if.ek_done) begin
            r_iter <= r_iter - 1'b1;
            if (r_iter == ITER_W'(1)) begin
               r_blk <= '0;
               r_rnd <= '0;
            end
         end

         if (r_state == S_ENC_WAIT && dp_if.enc_done) begin
            r_ctext[{r_blk, 1'b0}] <= dp_if.enc_resultL;
            r_ctext[{r_blk, 1'b1}] <= dp_if.enc_resultR;
            if (r_blk == 2'(ENC_BLOCKS - 1)) begin
               r_blk <= '0;
               r_rnd <= r_rnd + 1'b1;
            end else begin
               r_blk <= r_blk + 1'b1;
            end
         end

         if (r_state == S_DONE) begin
            r_hash       <= r_ctext;
            r_hash_valid <= 1'b1;
         end
      end
   end

   assign o_busy       = (r_state != S_IDLE);
   assign o_done       = r_done;
   assign o_error      = r_error;
   assign o_hash       = r_hash;
   assign o_hash_valid = r_hash_valid;

   assign dp_if.ek_start     = w_ek_req;
   assign dp_if.ek_load_salt = w_ek_req;
   assign dp_if.ek_key_sel   = w_ek_sel;
   assign dp_if.ek_salt      = w_salt_sel ? r_salt : '0;
   assign dp_if.enc_start    = w_enc_req;
   // blk is frozen across REQ/WAIT, so the block input holds until enc_done.
   assign dp_if.enc_L        = w_enc_act ? r_ctext[{r_blk, 1'b0}] : '0;
   assign dp_if.enc_R        = w_enc_act ? r_ctext[{r_blk, 1'b1}] : '0;

endmodule

// File: tb/tb_bcrypt_sched.sv
module tb_bcrypt_sched;

   localparam logic [191:0] MAGIC_HASH =
      192'h4F727068_65616E42_65686F6C_64657253_63727944_6F756274;

   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [4:0]   cost = '0;
   logic [127:0] salt = '0;
`ifdef BCRYPT_SCHED_ABORT_EN
   logic abort = 1'b0;
`endif
   logic busy, done, error, hash_valid;
   logic [191:0] hash;

   bcrypt_sched_if dp();

   logic        stub_ek_done = 1'b0, spur_ek_done = 1'b0, stub_enc_done = 1'b0;
   logic [31:0] stub_rl = '0, stub_rr = '0;
   assign dp.ek_done     = stub_ek_done | spur_ek_done;
   assign dp.enc_done    = stub_enc_done;
   assign dp.enc_resultL = stub_rl;
   assign dp.enc_resultR = stub_rr;

   bcrypt_sched #(.MAX_COST(30)) dut (
      .i_clk(clk), .i_reset(rst), .i_start(start), .i_cost(cost), .i_salt(salt),
`ifdef BCRYPT_SCHED_ABORT_EN
      .i_abort(abort),
`endif
      .o_busy(busy), .o_done(done), .o_error(error), .o_hash(hash),
      .o_hash_valid(hash_valid), .dp_if(dp)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int dly_mode = 0, dly_fixed = 0, enc_fn = 0;
   int run_id = 0, seen_id = 0;
   int ek_n = 0, enc_n = 0, err_n = 0, seq_bad = 0, hold_bad = 0;
   logic [127:0] cur_salt = '0;

   // Stub feistel: mode 0 inverts both halves, mode 1 mixes them.
   function automatic logic [63:0] enc_f(input logic [31:0] l, input logic [31:0] r, input int fn);
      if (fn == 0) return {~l, ~r};
      return {r ^ (l << 3) ^ 32'hA5A50F0F, l + r + 32'h12345677};
   endfunction

   // Reference: 64 rounds x 3 blocks over the magic text.
   function automatic logic [191:0] model_hash(input int fn);
      logic [31:0] w [6];
      logic [63:0] t;
      w = '{32'h4F727068, 32'h65616E42, 32'h65686F6C, 32'h64657253, 32'h63727944, 32'h6F756274};
      for (int r = 0; r < 64; r++)
         for (int b = 0; b < 3; b++) begin
            t = enc_f(w[2*b], w[2*b+1], fn);
            w[2*b] = t[63:32];
            w[2*b+1] = t[31:0];
         end
      return {w[0], w[1], w[2], w[3], w[4], w[5]};
   endfunction

   function automatic int pick_dly();
      if (dly_mode == 1) return int'($urandom_range(0, 20));
      if (dly_mode == 2) return dly_fixed;
      return 0;
   endfunction

   // Request monitor: pass k=0 is the salted setup, then key_sel 0,1,0,1...
   always @(negedge clk) begin
      if (run_id != seen_id) begin
         seen_id = run_id; ek_n = 0; enc_n = 0; err_n = 0; seq_bad = 0;
      end
      if (!rst) begin
         if (dp.ek_start === 1'b1) begin
            if (dp.ek_load_salt !== 1'b1 ||
                dp.ek_key_sel !== ((ek_n > 0) && (ek_n % 2 == 0)) ||
                dp.ek_salt !== ((ek_n == 0) ? cur_salt : 128'd0)) seq_bad++;
            ek_n++;
         end
         if (dp.enc_start === 1'b1) enc_n++;
         if (error === 1'b1) err_n++;
      end
   end

   // expandKey responder: delay 0 means done in the first WAIT cycle.
   initial begin
      int d;
      forever begin
         @(negedge clk);
         if (dp.ek_start === 1'b1 && !rst) begin
            d = pick_dly();
            @(posedge clk);
            repeat (d) @(posedge clk);
            #1 stub_ek_done = 1'b1;
            @(posedge clk);
            #1 stub_ek_done = 1'b0;
         end
      end
   end

   initial begin
      logic [31:0] cl, cr;
      int d;
      forever begin
         @(negedge clk);
         if (dp.enc_start === 1'b1 && !rst) begin
            cl = dp.enc_L; cr = dp.enc_R; d = pick_dly();
            @(posedge clk);
            repeat (d) @(posedge clk);
            #1;
            if (dp.enc_L !== cl || dp.enc_R !== cr) hold_bad++;
            {stub_rl, stub_rr} = enc_f(cl, cr, enc_fn);
            stub_enc_done = 1'b1;
            @(posedge clk);
            #1 stub_enc_done = 1'b0;
         end
      end
   end

   task automatic do_start(input logic [4:0] c, input logic [127:0] s);
      @(negedge clk);
      run_id++; cur_salt = s; cost = c; salt = s; start = 1'b1;
      @(posedge clk);
      #2 start = 1'b0;
   endtask

   task automatic wait_done(input bit poke, output int cyc);
      cyc = 0;
      while (done !== 1'b1 && cyc < 20000) begin
         @(posedge clk); #2; cyc++;
         if (poke && cyc == 40) begin start = 1'b1; cost = 5'd3; end
         if (poke && cyc == 41) start = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #2;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b want 00", done, error); end
      checks++; if (hash_valid !== 1'b0) begin errors++; $display("FAIL reset_hv got %b want 0", hash_valid); end
      checks++; if (hash !== 192'd0) begin errors++; $display("FAIL reset_hash got %h want 0", hash); end
      checks++; if ({dp.ek_start, dp.ek_load_salt, dp.ek_key_sel, dp.enc_start} !== 4'b0) begin errors++; $display("FAIL reset_req got %b want 0000", {dp.ek_start, dp.ek_load_salt, dp.ek_key_sel, dp.enc_start}); end
      checks++; if (dp.ek_salt !== 128'd0 || dp.enc_L !== 32'd0 || dp.enc_R !== 32'd0) begin errors++; $display("FAIL reset_data got %h %h %h want 0", dp.ek_salt, dp.enc_L, dp.enc_R); end
   endtask

   task automatic test_basic();
      int cyc;
      dly_mode = 0; enc_fn = 1;
      do_start(5'd4, 128'h0123456789ABCDEF0123456789ABCDEF);
      wait_done(1'b0, cyc);
      checks++; if (cyc !== 451) begin errors++; $display("FAIL basic_latency got %0d want 451", cyc); end
      checks++; if (ek_n !== 33) begin errors++; $display("FAIL basic_ek_count got %0d want 33", ek_n); end
      checks++; if (enc_n !== 192) begin errors++; $display("FAIL basic_enc_count got %0d want 192", enc_n); end
      checks++; if (seq_bad !== 0) begin errors++; $display("FAIL basic_ek_seq got %0d bad want 0", seq_bad); end
      checks++; if (hash !== model_hash(1)) begin errors++; $display("FAIL basic_hash got %h want %h", hash, model_hash(1)); end
      checks++; if (hash_valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_status got hv=%b busy=%b want 1 0", hash_valid, busy); end
      @(posedge clk); #2;
      checks++; if (done !== 1'b0 || hash_valid !== 1'b1) begin errors++; $display("FAIL basic_pulse got done=%b hv=%b want 0 1", done, hash_valid); end
   endtask

   task automatic test_hash_valid();
      int cyc;
      dly_mode = 0; enc_fn = 0;
      do_start(5'd4, {$urandom, $urandom, $urandom, $urandom});
      wait_done(1'b0, cyc);
      checks++; if (hash !== MAGIC_HASH) begin errors++; $display("FAIL inv_hash got %h want %h", hash, MAGIC_HASH); end
      checks++; if (hash_valid !== 1'b1) begin errors++; $display("FAIL inv_hv got %b want 1", hash_valid); end
      do_start(5'd4, {$urandom, $urandom, $urandom, $urandom});
      checks++; if (hash_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL hv_clear got hv=%b busy=%b want 0 1", hash_valid, busy); end
      wait_done(1'b0, cyc);
      checks++; if (cyc !== 451 || hash !== MAGIC_HASH) begin errors++; $display("FAIL inv_rerun got cyc=%0d hash=%h want 451 %h", cyc, hash, MAGIC_HASH); end
   endtask

   task automatic test_error();
      logic [4:0] bad [2];
      bad[0] = 5'd3; bad[1] = 5'd31;
      for (int i = 0; i < 2; i++) begin
         do_start(bad[i], 128'hDEAD);
         checks++; if (error !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL err_pulse cost=%0d got err=%b busy=%b want 1 0", bad[i], error, busy); end
         @(posedge clk); #2;
         checks++; if (error !== 1'b0) begin errors++; $display("FAIL err_width cost=%0d got %b want 0", bad[i], error); end
         repeat (5) @(posedge clk); #2;
         checks++; if (ek_n !== 0 || busy !== 1'b0 || err_n !== 1) begin errors++; $display("FAIL err_idle cost=%0d got ek=%0d busy=%b errs=%0d want 0 0 1", bad[i], ek_n, busy, err_n); end
         checks++; if (hash_valid !== 1'b1) begin errors++; $display("FAIL err_hv cost=%0d got %b want 1", bad[i], hash_valid); end
      end
   endtask

   task automatic test_random();
      int cyc;
      dly_mode = 1; enc_fn = 1;
      @(negedge clk) spur_ek_done = 1'b1;
      @(negedge clk) spur_ek_done = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL spur_idle got busy=%b want 0", busy); end
      do_start(5'd4, {$urandom, $urandom, $urandom, $urandom});
      wait_done(1'b1, cyc);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL rnd_timeout got done=%b after %0d cycles want 1", done, cyc); end
      checks++; if (ek_n !== 33 || enc_n !== 192) begin errors++; $display("FAIL rnd_counts got ek=%0d enc=%0d want 33 192", ek_n, enc_n); end
      checks++; if (seq_bad !== 0 || err_n !== 0) begin errors++; $display("FAIL rnd_seq got bad=%0d errs=%0d want 0 0", seq_bad, err_n); end
      checks++; if (hold_bad !== 0) begin errors++; $display("FAIL rnd_hold got %0d unstable want 0", hold_bad); end
      checks++; if (hash !== model_hash(1)) begin errors++; $display("FAIL rnd_hash got %h want %h", hash, model_hash(1)); end
   endtask

   task automatic test_reset_mid();
      int n, cyc;
      dly_mode = 2; dly_fixed = 6; enc_fn = 1;
      do_start(5'd4, {$urandom, $urandom, $urandom, $urandom});
      n = 0;
      while (ek_n < 14 && n < 2000) begin @(posedge clk); n++; end
      #2;
      checks++; if (ek_n !== 14 || busy !== 1'b1) begin errors++; $display("FAIL mid_reach got ek=%0d busy=%b want 14 1", ek_n, busy); end
      rst = 1'b1;
      @(posedge clk); #2;
      checks++; if (busy !== 1'b0 || hash_valid !== 1'b0 || hash !== 192'd0) begin errors++; $display("FAIL mid_reset got busy=%b hv=%b hash=%h want 0 0 0", busy, hash_valid, hash); end
      checks++; if (dp.ek_start !== 1'b0 || dp.ek_key_sel !== 1'b0 || dp.enc_L !== 32'd0) begin errors++; $display("FAIL mid_reset_dp got %b %b %h want 0 0 0", dp.ek_start, dp.ek_key_sel, dp.enc_L); end
      repeat (25) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      dly_mode = 0;
      do_start(5'd4, {$urandom, $urandom, $urandom, $urandom});
      wait_done(1'b0, cyc);
      checks++; if (cyc !== 451 || ek_n !== 33) begin errors++; $display("FAIL mid_rerun got cyc=%0d ek=%0d want 451 33", cyc, ek_n); end
      checks++; if (hash !== model_hash(1)) begin errors++; $display("FAIL mid_hash got %h want %h", hash, model_hash(1)); end
   endtask

`ifdef BCRYPT_SCHED_ABORT_EN
   task automatic test_abort();
      int n, bsy_bad;
      dly_mode = 2; dly_fixed = 4; enc_fn = 1;
      do_start(5'd4, 128'h55);
      n = 0;
      while (enc_n < 1 && n < 5000) begin @(posedge clk); n++; end
      #2 abort = 1'b1;
      @(posedge clk); #2 abort = 1'b0;
      n = 0; bsy_bad = 0;
      while (stub_enc_done !== 1'b1 && n < 50) begin
         if (busy !== 1'b1) bsy_bad++;
         @(posedge clk); #2; n++;
      end
      checks++; if (bsy_bad !== 0 || busy !== 1'b1) begin errors++; $display("FAIL abort_drain got bad=%0d busy=%b want 0 1", bsy_bad, busy); end
      @(posedge clk); #2;
      checks++; if (busy !== 1'b0 || done !== 1'b0 || hash_valid !== 1'b0) begin errors++; $display("FAIL abort_enc got busy=%b done=%b hv=%b want 0 0 0", busy, done, hash_valid); end
      repeat (3) @(posedge clk); #2;
      checks++; if (enc_n !== 1 || done !== 1'b0) begin errors++; $display("FAIL abort_enc_quiet got enc=%0d done=%b want 1 0", enc_n, done); end

      dly_mode = 0;
      do_start(5'd4, 128'h66);
      n = 0;
      while (ek_n < 1 && n < 100) begin @(posedge clk); n++; end
      @(posedge clk);
      #2 abort = 1'b1;
      #1;
      checks++; if (dp.ek_start !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL abort_req got ek_start=%b busy=%b want 0 1", dp.ek_start, busy); end
      @(posedge clk); #2 abort = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_lk_idle got busy=%b want 0", busy); end
      repeat (3) @(posedge clk); #2;
      checks++; if (ek_n !== 1 || hash_valid !== 1'b0) begin errors++; $display("FAIL abort_lk_quiet got ek=%0d hv=%b want 1 0", ek_n, hash_valid); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_hash_valid();
      test_error();
      test_random();
      test_reset_mid();
`ifdef BCRYPT_SCHED_ABORT_EN
      test_abort();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bcrypt_sched.md
Name: bcrypt_sched

Overview:
- Top-level sequencer for the EksBlowfish cost loop and the final ECB encryption.
- Drives the expandKey block through three phases:
  - one setup pass: password as key, real salt;
  - 2^cost alternating passes: password/zero-salt, then salt-as-key/zero-salt;
  - 64 rounds of 3-block encipher of the magic text through the feistel block.
- Sits between the host command interface and the expandKey/feistel datapath. Owns no SRAM port.

Parameters:
- MIN_COST, 4, smallest legal cost.
- MAX_COST, 31, largest legal cost; iteration counter width is MAX_COST+1 bits.
- ENC_ROUNDS, 64, number of encipher rounds over the 3-block text.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin hash; sampled only in IDLE.
- cost  in  5  log2 of the iteration count; latched with start.
- salt  in  128  salt; latched with start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on completion.
- error  out  1  one-cycle pulse when cost is out of range.
- hash  out  192  ciphertext words 0..5; word0 at [191:160].
- hash_valid  out  1  high from done until the next accepted start or reset.
- ek_start  out  1  one-cycle pulse requesting an expandKey pass.
- ek_load_salt  out  1  pulses with ek_start; expandKey latches ek_salt.
- ek_salt  out  128  latched salt in SETUP, else 0.
- ek_key_sel  out  1  0 = password bytes as key; 1 = salt bytes as key.
- ek_done  in  1  expandKey pass complete; high for at least one cycle.
- enc_start  out  1  one-cycle pulse requesting one feistel encipher.
- enc_L, enc_R  out  32 each  block input; held stable throughout ENC_WAIT.
- enc_resultL, enc_resultR  in  32 each  block result; valid when enc_done is high.
- enc_done  in  1  encipher complete.

Behaviour:
- Reset values:
  - state = IDLE;
  - busy, done, error, hash_valid, ek_start, ek_load_salt, enc_start all 0;
  - ek_salt = 0, ek_key_sel = 0, hash = 0, enc_L = enc_R = 0;
  - ctext words loaded with the magic constants.
- Reset mid-operation returns to IDLE next edge. Pending downstream dones are ignored.
- States and transitions:
  - IDLE: on start,
    - if cost < MIN_COST or cost > MAX_COST: error pulse next cycle, stay IDLE;
    - else latch salt and cost, set iter = 1<<cost, clear hash_valid, reload ctext with the magic words, go to SETUP_REQ.
  - Start while busy is ignored.
  - SETUP_REQ: ek_start = ek_load_salt = 1, ek_key_sel = 0, ek_salt = latched salt → SETUP_WAIT.
  - SETUP_WAIT: on ek_done → LK_REQ.
  - LK_REQ: ek_start = ek_load_salt = 1, ek_key_sel = 0, ek_salt = 0 → LK_WAIT.
  - LK_WAIT: on ek_done → LS_REQ.
  - LS_REQ: same as LK_REQ but ek_key_sel = 1 → LS_WAIT.
  - LS_WAIT: on ek_done, decrement iter. If the pre-decrement iter == 1 → ENC_REQ (blk = 0, rnd = 0), else → LK_REQ.
  - ENC_REQ: enc_start = 1, enc_L = ctext[2*blk], enc_R = ctext[2*blk+1] → ENC_WAIT.
  - ENC_WAIT: on enc_done,
    - write ctext[2*blk] = enc_resultL, ctext[2*blk+1] = enc_resultR;
    - blk wraps 2→0 and increments rnd;
    - if rnd == ENC_ROUNDS-1 and blk == 2 → DONE, else → ENC_REQ.
  - DONE: done = 1 for one cycle, hash = ctext concatenation, hash_valid = 1 → IDLE.
- Request-to-done rules:
  - ek_done/enc_done are only sampled in WAIT states; dones seen in REQ or IDLE are ignored.
  - A done arriving in the first WAIT cycle is legal.
- Counts for a full hash:
  - expandKey passes = 1 + 2·2^cost;
  - encipher requests = 3·ENC_ROUNDS.
- Magic words: 0x4F727068 0x65616E42 0x65686F6C 0x64657253 0x63727944 0x6F756274.
- Latency with single-cycle responders (done asserted in the first WAIT cycle): start-sample edge to done = 1 + 2·(passes + encipher requests) cycles.

Optional Feature:
- Macro: BCRYPT_SCHED_ABORT_EN.
- Enabled: adds input abort (1 bit).
  - In a REQ state: go to IDLE next cycle, with no request pulse issued.
  - In a WAIT state: go to DRAIN and wait for the outstanding ek_done/enc_done, then go to IDLE.
  - No done pulse, hash_valid stays 0, busy stays high through DRAIN.
  - abort in IDLE or DONE has no effect.
- Disabled: no abort port, no DRAIN state.

Decomposition:
- bcrypt_pkg holds:
  - the state enum;
  - the magic-word constant array;
  - MIN_COST default;
  - ENC_BLOCKS = 3.
- No sub-module needed. Counters, ctext register file and FSM live in one module.

Test Plan:
- cost=4, salt=128'h0123…CDEF, 1-cycle stub responders → 33 ek_start pulses:
  - first has ek_salt = salt, ek_key_sel = 0;
  - then alternating key_sel 0/1 with ek_salt = 0;
  - then 192 enc_start pulses, done exactly 451 cycles after start.
- Stub feistel returning ~L, ~R:
  - even round count gives hash = magic words;
  - check hash_valid = 1 and that it clears on the next start.
- cost=3 and cost=32'd… 5'd31 with MAX_COST=30 → error pulse, busy stays 0, no ek_start.
- Random 0–20 cycle ek_done/enc_done delays, spurious ek_done in IDLE, start pulsed while busy → pulse counts unchanged, no extra requests.
- reset asserted during LK_WAIT at iteration 7 → all outputs reset next cycle, a new start runs to a correct done.
- With BCRYPT_SCHED_ABORT_EN:
  - abort in ENC_WAIT, enc_done 5 cycles later → IDLE the cycle after enc_done, no done, hash_valid = 0;
  - abort in LK_REQ → IDLE next cycle, no ek_start.
